opcode_trace: RTL and testbench

OPCODE_TRACE -- requirements
Module: opcode_trace

---
 rtl/opcode_trace_pkg.sv | 23 ++
 rtl/opcode_trace_if.sv | 41 ++++
 rtl/opcode_trace_fifo.sv | 84 ++++++++
 rtl/opcode_trace.sv | 140 ++++++++++++++
 tb/tb_opcode_trace.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opcode_trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the opcode trace capture block.
//   A24_PREFIX    : opcode byte that marks a 24-bit-address prefix
//   AW_MAX        : widest CPU address the entry struct can carry
//   trace_entry_t : one traced instruction {opcode, pc, a24, seq}
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam logic [7:0] A24_PREFIX = 8'h1F;

  // The entry struct must have a fixed layout, so pc is sized for the widest
  // supported bus; narrower buses zero-extend into it.
  localparam int AW_MAX = 32;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [AW_MAX-1:0] pc;
    logic              a24;
    logic [7:0]        seq;
  } trace_entry_t;

endpackage

// File: rtl/opcode_trace_if.sv
// ---------------------------------------------------------------------------
// opcode_trace_if
// Valid/ready stream carrying traced instructions to the disassembler.
//   out_valid  : head entry present
//   out_ready  : consumer accepts the head entry
//   out_opcode : opcode byte
//   out_pc     : address of the first byte of the instruction
//   out_a24    : instruction carried the A24 prefix
//   out_seq    : instruction sequence number
// master = trace producer, slave = disassembler side.
// ---------------------------------------------------------------------------
interface opcode_trace_if #(
  parameter int AW = 24
) ();

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_opcode;
  logic [AW-1:0] out_pc;
  logic          out_a24;
  logic [7:0]    out_seq;

  modport master (
    output out_valid,
    input  out_ready,
    output out_opcode,
    output out_pc,
    output out_a24,
    output out_seq
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_opcode,
    input  out_pc,
    input  out_a24,
    input  out_seq
  );

endinterface

// File: rtl/opcode_trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic first-word-fall-through synchronous FIFO.
//   clk, RST_N : clock, asynchronous active-low reset
//   push, din  : write request and data
//   pop        : read request (ignored while empty)
//   clr        : synchronous flush, overrides push and pop
//   dout       : head entry; holds the last shown value while empty
//   full/empty : status flags
//   level      : current entry count
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   RST_N,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  input  logic                   clr,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [W-1:0]  hold_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign level   = count;
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  // While empty the output shows the hold register, which tracks whatever was
  // on dout the previous cycle, so the last entry stays visible.
  assign dout = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      hold_q <= dout;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/opcode_trace.sv
// ---------------------------------------------------------------------------
// opcode_trace
// Watches a CPU bus for opcode fetches and queues one entry per instruction
// for a downstream disassembler. A24 prefix bytes (8'h1F) are merged into
// the following instruction rather than queued on their own.
//   clk, RST_N        : clock, asynchronous active-low reset
//   AB, DI            : CPU address and read-data buses
//   SYNC, RDY         : opcode-fetch marker and CPU ready
//   enable            : capture enable, sampled with SYNC
//   clr               : synchronous flush of queue and counters
//   tout              : trace output stream (opcode_trace_if.master)
//   level             : entries currently queued
//   ovf_cnt           : instructions dropped because the queue was full
// AW must not exceed trace_pkg::AW_MAX.
// ---------------------------------------------------------------------------
module opcode_trace
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 24
) (
  input  logic                   clk,
  input  logic                   RST_N,
  input  logic [AW-1:0]          AB,
  input  logic [7:0]             DI,
  input  logic                   SYNC,
  input  logic                   RDY,
  input  logic                   enable,
  input  logic                   clr,
  opcode_trace_if.master         tout,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_cnt
);

  localparam int EW = $bits(trace_entry_t);

  logic          pend_q;
  logic [AW-1:0] pend_addr_q;
  logic [AW-1:0] prefix_pc_q;
  logic          a24_pend_q;
  logic [7:0]    seq_q;
  logic [7:0]    ovf_q;

  logic          fetch_ev;
  logic          sync_off;
  logic          capture;
  logic          is_prefix;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  trace_entry_t  cap_entry;
  trace_entry_t  head;

  // Decode this cycle's bus activity. The opcode byte arrives on the first
  // ready cycle after the fetch; a merged prefix supplies its own address.
  always_comb begin
    fetch_ev         = SYNC & RDY & enable;
    sync_off         = SYNC & RDY & ~enable;
    capture          = pend_q & RDY;
    is_prefix        = (DI == A24_PREFIX);
    push             = capture & ~is_prefix;
    pop              = tout.out_valid & tout.out_ready;
    drop             = push & full & ~pop;
    cap_entry        = '0;
    cap_entry.opcode = DI;
    cap_entry.pc     = AW_MAX'(a24_pend_q ? prefix_pc_q : pend_addr_q);
    cap_entry.a24    = a24_pend_q;
    cap_entry.seq    = seq_q;
  end

  // Fetch tracking, prefix merge and counters. A fetch in the capture cycle
  // re-arms the pending flag. A disabled fetch cancels any waiting prefix,
  // and that cancellation wins over a prefix captured in the same cycle.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      prefix_pc_q <= '0;
      a24_pend_q  <= 1'b0;
      seq_q       <= '0;
      ovf_q       <= '0;
    end else if (clr) begin
      pend_q      <= 1'b0;
      a24_pend_q  <= 1'b0;
      seq_q       <= '0;
      ovf_q       <= '0;
    end else begin
      if (fetch_ev) begin
        pend_addr_q <= AB;
        pend_q      <= 1'b1;
      end else if (capture) begin
        pend_q      <= 1'b0;
      end
      if (capture && is_prefix) begin
        if (!a24_pend_q) begin
          prefix_pc_q <= pend_addr_q;
        end
        a24_pend_q <= 1'b1;
      end else if (push) begin
        a24_pend_q <= 1'b0;
        seq_q      <= seq_q + 8'd1;
        if (drop && ovf_q != 8'hFF) begin
          ovf_q <= ovf_q + 8'd1;
        end
      end
      if (sync_off) begin
        a24_pend_q <= 1'b0;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .RST_N (RST_N),
    .push  (push),
    .din   (cap_entry),
    .pop   (pop),
    .clr   (clr),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    tout.out_valid  = ~empty;
    tout.out_opcode = head.opcode;
    tout.out_pc     = AW'(head.pc);
    tout.out_a24    = head.a24;
    tout.out_seq    = head.seq;
  end

  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_opcode_trace.sv
// ---------------------------------------------------------------------------
// tb_opcode_trace
// Self-checking bench for opcode_trace. A reference model predicts each
// queued entry when its opcode byte is driven and pushes it to a scoreboard;
// entries are popped and compared as the DUT hands them out.
// ---------------------------------------------------------------------------
module tb_opcode_trace;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 24;

  logic          clk = 1'b0;
  logic          RST_N;
  logic [AW-1:0] AB;
  logic [7:0]    DI;
  logic          SYNC;
  logic          RDY;
  logic          enable;
  logic          clr;
  logic [3:0]    level;
  logic [7:0]    ovf_cnt;

  opcode_trace_if #(.AW(AW)) tif ();

  opcode_trace #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .RST_N   (RST_N),
    .AB      (AB),
    .DI      (DI),
    .SYNC    (SYNC),
    .RDY     (RDY),
    .enable  (enable),
    .clr     (clr),
    .tout    (tif),
    .level   (level),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    op;
    logic [AW-1:0] pc;
    logic          a24;
    logic [7:0]    seq;
  } expEntry_t;

  expEntry_t     sb[$];
  int            errorCount = 0;
  int            checkCount = 0;
  int            modelCount = 0;
  logic [7:0]    mSeq       = 8'd0;
  logic [7:0]    mOvf       = 8'd0;
  logic          mA24       = 1'b0;
  logic [AW-1:0] mPc        = '0;
  logic          capValid   = 1'b0;
  logic          syncOff    = 1'b0;
  logic [7:0]    capOp      = 8'd0;
  logic [AW-1:0] capAddr    = '0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    modelCount = 0;
    mSeq       = 8'd0;
    mOvf       = 8'd0;
    mA24       = 1'b0;
  endtask

  // Predicts what one captured opcode byte does to the queue.
  task automatic modelCapture(input logic popNow);
    expEntry_t e;
    if (capOp == A24_PREFIX) begin
      if (!mA24) mPc = capAddr;
      mA24 = 1'b1;
    end else begin
      e.op  = capOp;
      e.pc  = mA24 ? mPc : capAddr;
      e.a24 = mA24;
      e.seq = mSeq;
      mSeq  = mSeq + 8'd1;
      mA24  = 1'b0;
      if (modelCount == DEPTH && !popNow) begin
        if (mOvf != 8'hFF) mOvf = mOvf + 8'd1;
      end else begin
        sb.push_back(e);
        modelCount++;
      end
    end
  endtask

  // One clock cycle: check status and the scoreboard at the falling edge,
  // update the model for the edge to come, then return 1 ns after the edge.
  task automatic tick();
    expEntry_t e;
    logic      popNow;
    @(negedge clk);
    popNow = 1'b0;
    if (RST_N) begin
      checkOutput("valid", tif.out_valid, modelCount != 0);
      checkOutput("level", level, modelCount);
      checkOutput("ovf", ovf_cnt, mOvf);
      if (clr) begin
        modelReset();
      end else begin
        if (tif.out_ready && modelCount != 0) begin
          e = sb.pop_front();
          checkOutput("head_op", tif.out_opcode, e.op);
          checkOutput("head_pc", tif.out_pc, e.pc);
          checkOutput("head_a24", tif.out_a24, e.a24);
          checkOutput("head_seq", tif.out_seq, e.seq);
          popNow = 1'b1;
        end
        if (capValid) modelCapture(popNow);
        if (syncOff) mA24 = 1'b0;
        if (popNow) modelCount--;
      end
    end
    @(posedge clk);
    #1;
    capValid = 1'b0;
    syncOff  = 1'b0;
  endtask

  // One instruction: fetch cycle at addr, opcode byte on the next cycle.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [7:0] op);
    AB     = addr;
    SYNC   = 1'b1;
    enable = 1'b1;
    RDY    = 1'b1;
    tick();
    SYNC     = 1'b0;
    DI       = op;
    capValid = 1'b1;
    capOp    = op;
    capAddr  = addr;
    tick();
    DI = 8'h00;
  endtask

  task automatic drainFifo();
    tif.out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && modelCount != 0; i++) tick();
    tick();
    tif.out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N         = 1'b0;
    AB            = '0;
    DI            = 8'h00;
    SYNC          = 1'b0;
    RDY           = 1'b1;
    enable        = 1'b1;
    clr           = 1'b0;
    tif.out_ready = 1'b0;
    #2;
    checkOutput("rst_valid", tif.out_valid, 1'b0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_opcode", tif.out_opcode, 8'h00);
    checkOutput("rst_pc", tif.out_pc, 24'h0);
    checkOutput("rst_seq", tif.out_seq, 8'h00);
    checkOutput("rst_ovf", ovf_cnt, 8'h00);
    @(posedge clk);
    #1;
    RST_N = 1'b1;
    tick();

    // Single fetch, head visible two cycles after SYNC
    tif.out_ready = 1'b1;
    applyStimulus(24'h001000, 8'hA9);
    checkOutput("lat_valid", tif.out_valid, 1'b1);
    checkOutput("lat_opcode", tif.out_opcode, 8'hA9);
    checkOutput("lat_pc", tif.out_pc, 24'h001000);
    checkOutput("lat_a24", tif.out_a24, 1'b0);
    checkOutput("lat_seq", tif.out_seq, 8'd0);
    tick();
    tick();
    checkOutput("hold_opcode", tif.out_opcode, 8'hA9);
    tif.out_ready = 1'b0;

    // Prefix merge
    applyStimulus(24'h002000, A24_PREFIX);
    applyStimulus(24'h002001, 8'hAD);
    checkOutput("pfx_level", level, 1);
    checkOutput("pfx_opcode", tif.out_opcode, 8'hAD);
    checkOutput("pfx_pc", tif.out_pc, 24'h002000);
    checkOutput("pfx_a24", tif.out_a24, 1'b1);

    // Consecutive prefixes keep the first prefix address
    applyStimulus(24'h003000, A24_PREFIX);
    applyStimulus(24'h003001, A24_PREFIX);
    applyStimulus(24'h003002, 8'hEA);
    checkOutput("pfx2_level", level, 2);

    // Disabled fetch cancels a waiting prefix
    applyStimulus(24'h004000, A24_PREFIX);
    AB      = 24'h004001;
    SYNC    = 1'b1;
    enable  = 1'b0;
    syncOff = 1'b1;
    tick();
    SYNC   = 1'b0;
    enable = 1'b1;
    tick();
    applyStimulus(24'h004002, 8'hEA);

    // Back-to-back: new fetch in the capture cycle
    AB   = 24'h005000;
    SYNC = 1'b1;
    tick();
    AB       = 24'h005001;
    DI       = 8'h8D;
    capValid = 1'b1;
    capOp    = 8'h8D;
    capAddr  = 24'h005000;
    tick();
    SYNC     = 1'b0;
    DI       = 8'h60;
    capValid = 1'b1;
    capOp    = 8'h60;
    capAddr  = 24'h005001;
    tick();
    checkOutput("b2b_level", level, 5);
    drainFifo();

    // RDY stall between fetch and opcode byte
    AB   = 24'h000300;
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    RDY  = 1'b0;
    DI   = 8'h55;
    repeat (3) tick();
    checkOutput("stall_level", level, 0);
    RDY      = 1'b1;
    DI       = 8'hEA;
    capValid = 1'b1;
    capOp    = 8'hEA;
    capAddr  = 24'h000300;
    tick();
    checkOutput("stall_opcode", tif.out_opcode, 8'hEA);
    checkOutput("stall_pc", tif.out_pc, 24'h000300);
    drainFifo();

    // Overflow after a flush
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(24'h006000 + AW'(i), 8'h40 + 8'(i));
    end
    checkOutput("ovf_level", level, DEPTH);
    checkOutput("ovf_count", ovf_cnt, 8'd3);
    checkOutput("ovf_head_seq", tif.out_seq, 8'd0);
    drainFifo();
    applyStimulus(24'h007000, 8'hC8);
    checkOutput("ovf_next_seq", tif.out_seq, 8'(DEPTH + 3));
    drainFifo();

    // Full queue with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(24'h00A000 + AW'(i), 8'h20 + 8'(i));
    end
    checkOutput("full_level", level, DEPTH);
    AB   = 24'h00B000;
    SYNC = 1'b1;
    tick();
    SYNC          = 1'b0;
    DI            = 8'hB5;
    capValid      = 1'b1;
    capOp         = 8'hB5;
    capAddr       = 24'h00B000;
    tif.out_ready = 1'b1;
    tick();
    tif.out_ready = 1'b0;
    checkOutput("fpop_level", level, DEPTH);
    checkOutput("fpop_ovf", ovf_cnt, 8'd3);
    drainFifo();

    // Asynchronous reset between fetch and opcode byte
    applyStimulus(24'h008000, 8'h11);
    applyStimulus(24'h008001, 8'h22);
    AB   = 24'h009000;
    SYNC = 1'b1;
    tick();
    SYNC  = 1'b0;
    DI    = 8'hA9;
    RST_N = 1'b0;
    #1;
    checkOutput("arst_valid", tif.out_valid, 1'b0);
    checkOutput("arst_level", level, 0);
    checkOutput("arst_opcode", tif.out_opcode, 8'h00);
    checkOutput("arst_pc", tif.out_pc, 24'h0);
    checkOutput("arst_a24", tif.out_a24, 1'b0);
    checkOutput("arst_seq", tif.out_seq, 8'h00);
    checkOutput("arst_ovf", ovf_cnt, 8'h00);
    modelReset();
    @(posedge clk);
    #1;
    RST_N = 1'b1;
    repeat (3) tick();
    tif.out_ready = 1'b1;
    applyStimulus(24'h00C000, 8'h42);
    checkOutput("post_rst_seq", tif.out_seq, 8'd0);
    drainFifo();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
